// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement sequencer.
package puf_pkg;

  // Sequencer states; each measurement phase walks CLR -> RUN -> SETTLE -> CAP.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    CAP    = 3'd4,
    CMP    = 3'd5
  } state_e;

  // Phase selector: which oscillator of the challenge pair is being measured.
  localparam logic PH_A = 1'b0;
  localparam logic PH_B = 1'b1;

  // Default widths of the oscillator select and of the captured counts.
  localparam int DEF_MUX_W = 2;
  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/puf_phase_timer.sv
// Loadable down-counter with a zero flag, used to time each sequencer state.
module puf_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/puf_measure_sequencer.sv
// Drives a fullChain ring-oscillator PUF through two gated measurement windows
// (oscillator A then oscillator B) and compares the captured counts into a
// response bit. Every output is registered and derived from the next state, so
// each output is valid in the same cycle as the state it belongs to.
module puf_measure_sequencer
  import puf_pkg::*;
#(
  parameter int MUX_W         = DEF_MUX_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int CLEAR_CYCLES  = 2,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [2*MUX_W-1:0] challenge,
  input  logic [CNT_W-1:0]   count_in,
  output logic [MUX_W-1:0]   mux_enable,
  output logic               puf_enable,
  output logic               reset_counter,
  output logic               busy,
  output logic               done,
  output logic               response,
  output logic               tie,
  output logic [CNT_W-1:0]   count_a,
  output logic [CNT_W-1:0]   count_b
);

  // The timer holds (duration - 1), so it only needs to reach the largest duration minus one.
  localparam int MAX_CW  = (CLEAR_CYCLES > WINDOW_CYCLES) ? CLEAR_CYCLES : WINDOW_CYCLES;
  localparam int MAX_CYC = (MAX_CW > SETTLE_CYCLES) ? MAX_CW : SETTLE_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e             state_q, state_d;
  logic               phase_q, phase_d;
  logic [MUX_W-1:0]   sel_b_q;
  logic [MUX_W-1:0]   mux_q, mux_d;
  logic               puf_q, rstc_q, busy_q, done_q, resp_q, tie_q;
  logic [CNT_W-1:0]   cnt_a_q, cnt_b_q;
  logic               tmr_load, tmr_zero;
  logic [TW-1:0]      tmr_val;

  puf_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state, phase, timer reload and the select to present on CLR entry.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    tmr_val  = '0;
    mux_d    = sel_b_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = CLR;
          phase_d = PH_A;
        end
      end
      CLR:    if (tmr_zero) state_d = RUN;
      RUN:    if (tmr_zero) state_d = SETTLE;
      SETTLE: if (tmr_zero) state_d = CAP;
      CAP: begin
        if (phase_q == PH_A) begin
          state_d = CLR;
          phase_d = PH_B;
        end else begin
          state_d = CMP;
        end
      end
      CMP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort beats everything, including a start arriving in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    // Phase A's select comes straight from the challenge being accepted now.
    if (state_q == IDLE) begin
      mux_d = challenge[MUX_W-1:0];
    end

    tmr_load = (state_d != state_q);
    case (state_d)
      CLR:     tmr_val = TW'(CLEAR_CYCLES - 1);
      RUN:     tmr_val = TW'(WINDOW_CYCLES - 1);
      SETTLE:  tmr_val = TW'(SETTLE_CYCLES - 1);
      default: tmr_val = '0;
    endcase
  end

  // State and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_A;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Registered outputs, captured counts and the latched B select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_b_q <= '0;
      mux_q   <= '0;
      puf_q   <= 1'b0;
      rstc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= 1'b0;
      tie_q   <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      rstc_q <= (state_d == CLR);
      puf_q  <= (state_d == RUN);
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == CMP);
      if ((state_q == IDLE) && (state_d == CLR)) begin
        sel_b_q <= challenge[2*MUX_W-1:MUX_W];
      end
      // The select only moves when a clear window opens, never mid-measurement.
      if ((state_d == CLR) && (state_q != CLR)) begin
        mux_q <= mux_d;
      end
      if (state_d == CAP) begin
        if (phase_q == PH_A) begin
          cnt_a_q <= count_in;
        end else begin
          cnt_b_q <= count_in;
        end
      end
      if (state_d == CMP) begin
        resp_q <= (cnt_a_q > cnt_b_q);
        tie_q  <= (cnt_a_q == cnt_b_q);
      end
    end
  end

  assign mux_enable    = mux_q;
  assign puf_enable    = puf_q;
  assign reset_counter = rstc_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign response      = resp_q;
  assign tie           = tie_q;
  assign count_a       = cnt_a_q;
  assign count_b       = cnt_b_q;

endmodule
